serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/serial_fa_cell.sv | 13 +
 rtl/serial_add_ctrl.sv | 118 +++++++++++
 tb/tb_serial_add_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder used as the single arithmetic cell of the serial adder.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one sum bit per cycle through a single full-adder cell.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             flush,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;

  serial_fa_cell u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .ci  (carry),
    .sum (fa_s),
    .co  (fa_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (flush) begin
      // Abort wins over everything, including a simultaneous request in IDLE.
      state     <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_sr      <= op_a;
            b_sr      <= op_b;
            carry     <= cin;
            cnt       <= '0;
            state     <= RUN;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {fa_s, res_sr[WIDTH-1:1]};
          carry  <= fa_co;
          if (cnt == LAST) begin
            // Final bit: publish the assembled result in the same edge.
            sum       <= {fa_s, res_sr[WIDTH-1:1]};
            cout      <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
            ovf       <= carry ^ fa_co;
`endif
            state     <= DONE;
            busy      <= 1'b0;
            res_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8); ovf checks follow SERIAL_ADD_OVF_EN.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       cin;
  logic       flush;
  logic       busy;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .flush     (flush),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge with the controller idle; returns at the negedge after the accept edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic ci);
    chk("req_ready_before_accept", 64'(req_ready), 64'd1);
    op_a      = a;
    op_b      = b;
    cin       = ci;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!res_valid && lat < 50) begin
      if (busy) bcnt++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_after_hs", 64'(res_valid), 64'd0);
    chk("req_ready_after_hs", 64'(req_ready), 64'd1);
  endtask

  initial begin
    int lat;
    int bcnt;
    int seen;
    logic [7:0] held_sum;
    logic       held_cout;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};

    rst       = 1'b1;
    req_valid = 1'b0;
    op_a      = '0;
    op_b      = '0;
    cin       = 1'b0;
    flush     = 1'b0;
    res_ready = 1'b0;

    // Reset state, observed while reset is held.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven operations with full latency and busy-length checks.
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].ci);
      wait_result(lat, bcnt);
      chk("latency", 64'(lat), 64'd8);
      chk("busy_cycles", 64'(bcnt), 64'd8);
      chk("sum", 64'(sum), 64'(vecs[i].s));
      chk("cout", 64'(cout), 64'(vecs[i].co));
      chk("req_ready_in_done", 64'(req_ready), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
      chk("ovf", 64'(ovf), 64'(vecs[i].ov));
`endif
      handshake();
    end

    // Result held under backpressure; a competing request must be ignored.
    start_op(8'h5A, 8'h3C, 1'b1);
    wait_result(lat, bcnt);
    chk("hold_latency", 64'(lat), 64'd8);
    held_sum  = sum;
    held_cout = cout;
    chk("hold_sum_initial", 64'(held_sum), 64'h97);
    op_a      = 8'h11;
    op_b      = 8'h22;
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_res_valid", 64'(res_valid), 64'd1);
      chk("hold_sum", 64'(sum), 64'(held_sum));
      chk("hold_cout", 64'(cout), 64'(held_cout));
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    handshake();
    @(posedge clk);
    @(negedge clk);
    chk("no_accept_busy", 64'(busy), 64'd0);

    // Flush during the 4th RUN cycle.
    start_op(8'hFF, 8'h01, 1'b0);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_req_ready", 64'(req_ready), 64'd1);
    chk("flush_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (res_valid) seen++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("flush_no_res_valid", 64'(seen), 64'd0);
    start_op(8'h01, 8'h01, 1'b0);
    wait_result(lat, bcnt);
    chk("post_flush_latency", 64'(lat), 64'd8);
    chk("post_flush_sum", 64'(sum), 64'h02);
    chk("post_flush_cout", 64'(cout), 64'd0);
    handshake();

    // Flush with a simultaneous request in IDLE must not accept.
    op_a      = 8'h33;
    op_b      = 8'h44;
    req_valid = 1'b1;
    flush     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
    chk("flush_idle_busy", 64'(busy), 64'd0);
    chk("flush_idle_req_ready", 64'(req_ready), 64'd1);

    // Asynchronous reset mid-RUN; sum still holds the last result (0x02).
    start_op(8'h5A, 8'h3C, 1'b1);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("pre_rst_sum", 64'(sum), 64'h02);
    #2 rst = 1'b1;
    #1;
    chk("arst_req_ready", 64'(req_ready), 64'd1);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_res_valid", 64'(res_valid), 64'd0);
    chk("arst_sum", 64'(sum), 64'd0);
    chk("arst_cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (res_valid) seen++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("rst_no_res_valid", 64'(seen), 64'd0);
    start_op(8'h5A, 8'h3C, 1'b1);
    wait_result(lat, bcnt);
    chk("post_rst_latency", 64'(lat), 64'd8);
    chk("post_rst_sum", 64'(sum), 64'h97);
    chk("post_rst_cout", 64'(cout), 64'd0);
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
